// File: rtl/mat_mult_engine_if.sv
// Operand-load, control and result-stream bundle for mat_mult_engine.
// The engine takes the slave side; the loader/result-RAM side takes master.
interface mat_mult_engine_if #(
    parameter int DIM    = 8,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 19
);
    localparam int AW = $clog2(DIM*DIM);
    localparam int CW = 3*AW/2 + 2;

    logic                     start;
    logic                     abort;
    logic                     ld_a_we;
    logic                     ld_b_we;
    logic [AW-1:0]            ld_addr;
    logic signed [DATA_W-1:0] ld_data;
    logic                     busy;
    logic                     done;
    logic                     res_valid;
    logic [AW-1:0]            res_addr;
    logic signed [OUT_W-1:0]  res_data;
    logic [CW-1:0]            cycle_count;

    modport master (
        output start, abort, ld_a_we, ld_b_we, ld_addr, ld_data,
        input  busy, done, res_valid, res_addr, res_data, cycle_count
    );

    modport slave (
        input  start, abort, ld_a_we, ld_b_we, ld_addr, ld_data,
        output busy, done, res_valid, res_addr, res_data, cycle_count
    );
endinterface

// File: rtl/mat_mult_engine.sv
// Signed DIM x DIM matrix multiplier, one MAC per cycle, with loadable operand
// memories, start/busy/done handshake, abort, result stream and cycle counter.
module mat_mult_engine #(
    parameter int DIM    = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(DIM) + 1,
    parameter int OUT_W  = 19,
    parameter int SAT    = 0,
    parameter int AW     = $clog2(DIM*DIM)
) (
    input  logic             clk,
    input  logic             reset_n,
    mat_mult_engine_if.slave bus
);
    localparam int NE = DIM*DIM;
    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CW = 3*AW/2 + 2;
    localparam int PW = 2*DATA_W;
    localparam int EW = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic [IW-1:0] LAST_IDX = IW'(DIM-1);
    localparam logic [AW-1:0] DIM_A    = AW'(DIM);

    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]               state;
    logic [IW-1:0]            i_idx, j_idx, k_idx;
    logic                     drain_cnt;
    logic                     done_q;
    logic [CW-1:0]            cycle_cnt;
    logic                     abort_now;

    logic signed [DATA_W-1:0] mem_a [NE];
    logic signed [DATA_W-1:0] mem_b [NE];
    logic signed [DATA_W-1:0] a_q, b_q;
    logic [AW-1:0]            addr_a, addr_b, addr_c;

    logic                     s1_valid, s1_first, s1_last;
    logic [AW-1:0]            s1_addr;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc, acc_base, acc_next;
    logic signed [EW-1:0]     acc_ext;
    logic signed [OUT_W-1:0]  res_sat;
    logic                     res_valid_q;
    logic [AW-1:0]            res_addr_q;
    logic signed [OUT_W-1:0]  res_data_q;

    assign abort_now = bus.abort && (state != IDLE);

    always_comb begin
        addr_a = AW'(i_idx) * DIM_A + AW'(k_idx);
        addr_b = AW'(k_idx) * DIM_A + AW'(j_idx);
        addr_c = AW'(i_idx) * DIM_A + AW'(j_idx);
    end

    // Operand memories are loadable only while idle and are never reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && int'(bus.ld_addr) < NE) begin
            if (bus.ld_a_we) mem_a[bus.ld_addr] <= bus.ld_data;
            if (bus.ld_b_we) mem_b[bus.ld_addr] <= bus.ld_data;
        end
        a_q <= mem_a[addr_a];
        b_q <= mem_b[addr_b];
    end

    // Product, accumulate (restarting on k==0) and the output width conversion.
    always_comb begin
        prod     = PW'(a_q) * PW'(b_q);
        acc_base = acc;
        if (s1_first) acc_base = '0;
        acc_next = acc_base + ACC_W'(prod);
        acc_ext  = EW'(acc_next);
        res_sat  = acc_ext[OUT_W-1:0];
        if (SAT != 0) begin
            if (acc_ext > SAT_MAX)      res_sat = SAT_MAX[OUT_W-1:0];
            else if (acc_ext < SAT_MIN) res_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    // Sequencer: k fastest, then j, then i; two drain cycles flush the pipeline.
    // The acceptance cycle itself is counted, so a full run ends at DIM^3+3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            drain_cnt <= 1'b0;
            done_q    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        done_q    <= 1'b0;
                        cycle_cnt <= CW'(1);
                        i_idx     <= '0;
                        j_idx     <= '0;
                        k_idx     <= '0;
                    end
                end
                RUN: begin
                    cycle_cnt <= cycle_cnt + CW'(1);
                    if (abort_now) begin
                        state <= IDLE;
                        i_idx <= '0;
                        j_idx <= '0;
                        k_idx <= '0;
                    end else if (k_idx != LAST_IDX) begin
                        k_idx <= k_idx + IW'(1);
                    end else begin
                        k_idx <= '0;
                        if (j_idx != LAST_IDX) begin
                            j_idx <= j_idx + IW'(1);
                        end else begin
                            j_idx <= '0;
                            if (i_idx != LAST_IDX) begin
                                i_idx <= i_idx + IW'(1);
                            end else begin
                                i_idx     <= '0;
                                state     <= DRAIN;
                                drain_cnt <= 1'b0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    cycle_cnt <= cycle_cnt + CW'(1);
                    if (abort_now) begin
                        state <= IDLE;
                    end else if (drain_cnt) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage MAC pipeline: registered operand read, then accumulate/emit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_addr     <= '0;
            acc         <= '0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
        end else if (abort_now) begin
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            acc         <= '0;
            res_valid_q <= 1'b0;
        end else begin
            s1_valid    <= (state == RUN);
            s1_first    <= (k_idx == '0);
            s1_last     <= (k_idx == LAST_IDX);
            s1_addr     <= addr_c;
            res_valid_q <= s1_valid && s1_last;
            if (s1_valid) begin
                acc <= acc_next;
                if (s1_last) begin
                    res_addr_q <= s1_addr;
                    res_data_q <= res_sat;
                end
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_addr    = res_addr_q;
    assign bus.res_data    = res_data_q;
    assign bus.cycle_count = cycle_cnt;
endmodule

// File: tb/tb_mat_mult_engine.sv
// Self-checking bench: two DIM=8 engines (truncating OUT_W=19, saturating
// OUT_W=16) share one stimulus stream; a DIM=4/DATA_W=4 engine runs separately.
module tb_mat_mult_engine;
    localparam int D0     = 8;
    localparam int NE0    = D0*D0;
    localparam int RUNLEN = D0*D0*D0;
    localparam int BUDGET = 700;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    int matA [NE0];
    int matB [NE0];
    int expFull [NE0];
    int expArr0 [NE0];
    int expArr1 [NE0];

    typedef struct {
        string name;
        int    aVal;
        int    bVal;
        int    exp19;
        int    exp16;
    } fillVec_t;

    fillVec_t vecs [6];

    mat_mult_engine_if #(.DIM(8), .DATA_W(8), .OUT_W(19)) if0 ();
    mat_mult_engine_if #(.DIM(8), .DATA_W(8), .OUT_W(16)) if1 ();
    mat_mult_engine_if #(.DIM(4), .DATA_W(4), .OUT_W(19)) if2 ();

    assign if1.start   = if0.start;
    assign if1.abort   = if0.abort;
    assign if1.ld_a_we = if0.ld_a_we;
    assign if1.ld_b_we = if0.ld_b_we;
    assign if1.ld_addr = if0.ld_addr;
    assign if1.ld_data = if0.ld_data;

    mat_mult_engine #(.DIM(8), .DATA_W(8), .OUT_W(19), .SAT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave));
    mat_mult_engine #(.DIM(8), .DATA_W(8), .OUT_W(16), .SAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave));
    mat_mult_engine #(.DIM(4), .DATA_W(4), .OUT_W(19), .SAT(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    function automatic int truncTo(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        if (m >= (1 << (w-1))) m = m - (1 << w);
        return m;
    endfunction

    function automatic int satTo(input int v, input int w);
        if (v > (1 << (w-1)) - 1) return (1 << (w-1)) - 1;
        if (v < -(1 << (w-1)))    return -(1 << (w-1));
        return v;
    endfunction

    // C = A x B straight from the definition, then both output conversions.
    function automatic void modelExpected();
        for (int i = 0; i < D0; i++)
            for (int j = 0; j < D0; j++) begin
                expFull[i*D0+j] = 0;
                for (int k = 0; k < D0; k++)
                    expFull[i*D0+j] += matA[i*D0+k] * matB[k*D0+j];
            end
        for (int n = 0; n < NE0; n++) begin
            expArr0[n] = truncTo(expFull[n], 19);
            expArr1[n] = satTo(expFull[n], 16);
        end
    endfunction

    function automatic void randomMatrices();
        for (int n = 0; n < NE0; n++) begin
            matA[n] = int'($urandom_range(0, 255)) - 128;
            matB[n] = int'($urandom_range(0, 255)) - 128;
        end
    endfunction

    // mode 1: A then B; mode 2: as 1 with start on the last B write;
    // mode 3: single pass with both enables (requires matA == matB).
    task automatic applyStimulus(input int mode);
        if (mode == 3) begin
            for (int n = 0; n < NE0; n++) begin
                @(negedge clk);
                if0.ld_a_we = 1'b1; if0.ld_b_we = 1'b1;
                if0.ld_addr = 6'(n); if0.ld_data = 8'(matA[n]);
            end
        end else begin
            for (int n = 0; n < NE0; n++) begin
                @(negedge clk);
                if0.ld_a_we = 1'b1; if0.ld_b_we = 1'b0;
                if0.ld_addr = 6'(n); if0.ld_data = 8'(matA[n]);
            end
            for (int n = 0; n < NE0; n++) begin
                @(negedge clk);
                if0.ld_a_we = 1'b0; if0.ld_b_we = 1'b1;
                if0.ld_addr = 6'(n); if0.ld_data = 8'(matB[n]);
                if (mode == 2 && n == NE0-1) if0.start = 1'b1;
            end
        end
    endtask

    task automatic startNow();
        @(negedge clk);
        if0.ld_a_we = 1'b0; if0.ld_b_we = 1'b0;
        if0.start = 1'b1;
    endtask

    task automatic runCase(input string tag, input int mode, input bit disturb);
        int cyc, doneCyc, lastPulse, ccAtDone, busyAtDone;
        int pulses0, pulses1, orderErr, dataErr0, dataErr1;
        cyc = 0; doneCyc = -1; lastPulse = -1; ccAtDone = -1; busyAtDone = -1;
        pulses0 = 0; pulses1 = 0; orderErr = 0; dataErr0 = 0; dataErr1 = 0;
        if (mode != 0) applyStimulus(mode);
        if (mode != 2) startNow();
        while (cyc < BUDGET && doneCyc < 0) begin
            @(negedge clk);
            cyc++;
            if (if0.res_valid) begin
                if (int'(if0.res_addr) != pulses0) orderErr++;
                if (pulses0 >= NE0 || int'(if0.res_data) != expArr0[pulses0]) dataErr0++;
                lastPulse = cyc;
                pulses0++;
            end
            if (if1.res_valid) begin
                if (int'(if1.res_addr) != pulses1) orderErr++;
                if (pulses1 >= NE0 || int'(if1.res_data) != expArr1[pulses1]) dataErr1++;
                pulses1++;
            end
            if (if0.done) begin
                doneCyc    = cyc;
                ccAtDone   = int'(if0.cycle_count);
                busyAtDone = int'(if0.busy);
            end
            if0.start = 1'b0; if0.ld_a_we = 1'b0; if0.ld_b_we = 1'b0;
            if (disturb && (cyc == 10 || cyc == 300)) begin
                if0.ld_a_we = 1'b1; if0.ld_b_we = 1'b1;
                if0.ld_addr = 6'(0); if0.ld_data = 8'(matA[0] + 1);
                if0.start = 1'b1;
            end
        end
        checkOutput({tag, " done seen"}, longint'(doneCyc >= 0), 1);
        checkOutput({tag, " pulses trunc"}, pulses0, NE0);
        checkOutput({tag, " pulses sat"}, pulses1, NE0);
        checkOutput({tag, " addr order errs"}, orderErr, 0);
        checkOutput({tag, " data errs trunc"}, dataErr0, 0);
        checkOutput({tag, " data errs sat"}, dataErr1, 0);
        checkOutput({tag, " last pulse cycle"}, lastPulse, RUNLEN + 2);
        checkOutput({tag, " done cycle"}, doneCyc, RUNLEN + 3);
        checkOutput({tag, " cycle_count"}, ccAtDone, RUNLEN + 3);
        checkOutput({tag, " busy at done"}, busyAtDone, 0);
    endtask

    task automatic abortRun();
        int cc, pulsesAfter;
        randomMatrices();
        modelExpected();
        applyStimulus(1);
        startNow();
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if0.start = 1'b0;
        end
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        checkOutput("abort busy", if0.busy, 0);
        checkOutput("abort busy sat", if1.busy, 0);
        checkOutput("abort res_valid", if0.res_valid, 0);
        checkOutput("abort done", if0.done, 0);
        cc = int'(if0.cycle_count);
        checkOutput("abort count held", longint'(cc == 100 || cc == 101), 1);
        pulsesAfter = 0;
        repeat (30) begin
            @(negedge clk);
            if (if0.res_valid || if1.res_valid) pulsesAfter++;
        end
        cc = int'(if0.cycle_count);
        checkOutput("abort no pulses", pulsesAfter, 0);
        checkOutput("abort done stays 0", if0.done, 0);
        checkOutput("abort count frozen", longint'(cc == 100 || cc == 101), 1);
        runCase("restart after abort", 0, 1'b0);
    endtask

    task automatic finalDrainAbort();
        startNow();
        for (int c = 1; c <= RUNLEN + 2; c++) begin
            @(negedge clk);
            if0.start = 1'b0;
        end
        checkOutput("final drain last pulse", if0.res_valid, 1);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        checkOutput("final drain abort busy", if0.busy, 0);
        checkOutput("final drain abort done", if0.done, 0);
        repeat (3) @(negedge clk);
        checkOutput("final drain done stays 0", if0.done, 0);
    endtask

    task automatic resetMidDrain();
        startNow();
        for (int c = 1; c <= RUNLEN + 1; c++) begin
            @(negedge clk);
            if0.start = 1'b0;
        end
        checkOutput("pre-reset busy", if0.busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid-drain reset busy", if0.busy, 0);
        checkOutput("mid-drain reset done", if0.done, 0);
        checkOutput("mid-drain reset res_valid", if0.res_valid, 0);
        checkOutput("mid-drain reset res_addr", if0.res_addr, 0);
        checkOutput("mid-drain reset res_data", if0.res_data, 0);
        checkOutput("mid-drain reset cycle_count", if0.cycle_count, 0);
        checkOutput("mid-drain reset sat res_data", if1.res_data, 0);
        repeat (2) @(negedge clk);
        checkOutput("held reset res_valid", if0.res_valid, 0);
        reset_n = 1'b1;
        runCase("after reset", 0, 1'b0);
    endtask

    task automatic runSmall();
        int a4 [16];
        int b4 [16];
        int e4 [16];
        int cyc, doneCyc, lastPulse, ccAtDone, pulses, orderErr, dataErr;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a4[i*4+k] = i + k;
                b4[i*4+k] = i - k;
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                e4[i*4+j] = 0;
                for (int k = 0; k < 4; k++) e4[i*4+j] += a4[i*4+k] * b4[k*4+j];
            end
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if2.ld_a_we = 1'b1; if2.ld_b_we = 1'b0;
            if2.ld_addr = 4'(n); if2.ld_data = 4'(a4[n]);
        end
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if2.ld_a_we = 1'b0; if2.ld_b_we = 1'b1;
            if2.ld_addr = 4'(n); if2.ld_data = 4'(b4[n]);
        end
        @(negedge clk);
        if2.ld_b_we = 1'b0; if2.start = 1'b1;
        cyc = 0; doneCyc = -1; lastPulse = -1; ccAtDone = -1;
        pulses = 0; orderErr = 0; dataErr = 0;
        while (cyc < 200 && doneCyc < 0) begin
            @(negedge clk);
            cyc++;
            if2.start = 1'b0;
            if (if2.res_valid) begin
                if (int'(if2.res_addr) != pulses) orderErr++;
                if (pulses >= 16 || int'(if2.res_data) != truncTo(e4[pulses], 19)) dataErr++;
                lastPulse = cyc;
                pulses++;
            end
            if (if2.done) begin
                doneCyc  = cyc;
                ccAtDone = int'(if2.cycle_count);
            end
        end
        checkOutput("dim4 pulses", pulses, 16);
        checkOutput("dim4 addr order errs", orderErr, 0);
        checkOutput("dim4 data errs", dataErr, 0);
        checkOutput("dim4 last pulse cycle", lastPulse, 66);
        checkOutput("dim4 done cycle", doneCyc, 67);
        checkOutput("dim4 cycle_count", ccAtDone, 67);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        vecs[0] = '{"all -128 x -128", -128, -128, 131072, 32767};
        vecs[1] = '{"127 x -128", 127, -128, -130048, -32768};
        vecs[2] = '{"127 x 127", 127, 127, 129032, 32767};
        vecs[3] = '{"-1 x 1", -1, 1, -8, -8};
        vecs[4] = '{"3 x -5", 3, -5, -120, -120};
        vecs[5] = '{"0 x 99", 0, 99, 0, 0};

        reset_n = 1'b1;
        if0.start = 1'b0; if0.abort = 1'b0; if0.ld_a_we = 1'b0; if0.ld_b_we = 1'b0;
        if0.ld_addr = '0; if0.ld_data = '0;
        if2.start = 1'b0; if2.abort = 1'b0; if2.ld_a_we = 1'b0; if2.ld_b_we = 1'b0;
        if2.ld_addr = '0; if2.ld_data = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", if0.busy, 0);
        checkOutput("reset done", if0.done, 0);
        checkOutput("reset res_valid", if0.res_valid, 0);
        checkOutput("reset res_addr", if0.res_addr, 0);
        checkOutput("reset res_data", if0.res_data, 0);
        checkOutput("reset cycle_count", if0.cycle_count, 0);
        checkOutput("reset dim4 busy", if2.busy, 0);
        reset_n = 1'b1;

        for (int n = 0; n < NE0; n++) begin
            matA[n]    = (n / D0 == n % D0) ? 1 : 0;
            matB[n]    = n - 32;
            expArr0[n] = n - 32;
            expArr1[n] = n - 32;
        end
        runCase("identity", 1, 1'b0);

        @(negedge clk);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        checkOutput("idle abort keeps done", if0.done, 1);
        checkOutput("idle abort busy", if0.busy, 0);

        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < NE0; n++) begin
                matA[n]    = vecs[r].aVal;
                matB[n]    = vecs[r].bVal;
                expArr0[n] = vecs[r].exp19;
                expArr1[n] = vecs[r].exp16;
            end
            runCase(vecs[r].name, (vecs[r].aVal == vecs[r].bVal) ? 3 : 1, 1'b0);
        end

        for (int t = 0; t < 2; t++) begin
            randomMatrices();
            modelExpected();
            runCase("random", 1, 1'b0);
        end

        randomMatrices();
        modelExpected();
        runCase("start with last load", 2, 1'b0);
        runCase("busy ignores load and start", 0, 1'b1);

        abortRun();
        finalDrainAbort();
        resetMidDrain();
        runSmall();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mat_mult_engine.md
Name: mat_mult_engine

Overview:
- Parametrised signed DIM x DIM matrix multiplier computing C = A x B with one multiply-accumulate per cycle.
- Successor to the fixed 8x8 MAC-based multiplier in the design.
- Adds loadable operand memories, a start/busy/done handshake, abort, a result stream, an output saturation mode and cycle counting.
- Sits between the operand loader (host/test logic) and the result RAM.

Parameters:
- DIM, 8, matrix dimension (2..16); all matrices row-major, DIM*DIM entries.
- DATA_W, 8, signed operand width.
- ACC_W, 2*DATA_W+$clog2(DIM)+1, signed accumulator width; must never overflow.
- OUT_W, 19, signed result width on res_data.
- SAT, 0, 1 = saturate accumulator to OUT_W; 0 = keep low OUT_W bits.
- AW, $clog2(DIM*DIM), operand/result address width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request computation; accepted only in IDLE.
- abort  in  1  synchronous abort of a running computation.
- ld_a_we  in  1  write enable, A memory.
- ld_b_we  in  1  write enable, B memory.
- ld_addr  in  AW  load address (row*DIM+col).
- ld_data  in  DATA_W  signed load data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  sticky completion flag.
- res_valid  out  1  one-cycle strobe per C element.
- res_addr  out  AW  C element address i*DIM+j.
- res_data  out  OUT_W  signed C element.
- cycle_count  out  3*AW/2+2  cycles from start acceptance to done.

Behaviour:
- Reset (async, reset_n=0) forces:
  - state=IDLE; busy=0, done=0, res_valid=0, res_addr=0, res_data=0, cycle_count=0.
  - Internal indices i, j, k = 0; accumulator = 0.
  - Operand memory contents are not reset.
- Loads:
  - ld_a_we/ld_b_we write ld_data at ld_addr on the clock edge, only in IDLE. Ignored otherwise.
  - Both enables high writes the same data to both memories.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 -> RUN; clears done and cycle_count; sets i=j=k=0.
  - start and a load in the same cycle: the load completes, then start is accepted.
- RUN (issue order: k fastest, then j, then i):
  - Each cycle issues the address pair A[i*DIM+k], B[k*DIM+j].
  - Operand read is registered (1 cycle). The product is added to the accumulator the next cycle, giving a 2-cycle pipeline.
  - When k=DIM-1, the accumulator restarts from the next product. Back-to-back elements need no bubble.
  - After issuing (DIM-1, DIM-1, DIM-1) -> DRAIN.
- DRAIN: 2 cycles to flush the pipeline, then -> IDLE with done=1.
- Result output:
  - res_valid pulses 2 cycles after the issue with k=DIM-1, carrying res_addr=i*DIM+j.
  - Exactly DIM*DIM pulses per run, in address order 0..DIM*DIM-1.
- Timing:
  - The first issue happens in the cycle after start acceptance.
  - The last res_valid occurs DIM^3+2 cycles after acceptance; done rises on the next edge.
  - cycle_count increments every cycle in RUN/DRAIN and freezes at done; value DIM^3+3 (515 for DIM=8).
- Arithmetic:
  - Full-precision signed product (2*DATA_W), sign-extended to ACC_W.
  - SAT=1: values above 2^(OUT_W-1)-1 clamp to that value; values below -2^(OUT_W-1) clamp to that value.
  - SAT=0: two's-complement truncation.
- done:
  - Stays high in IDLE until the next accepted start.
  - start while busy is ignored and does not extend done.
- abort:
  - Sampled in RUN/DRAIN -> IDLE next edge.
  - res_valid is forced 0 that cycle and no further writes occur; done stays 0.
  - Pipeline and accumulator are cleared; cycle_count holds.
  - abort in IDLE has no effect.
- Reset mid-run: immediate IDLE, no result pulse; a new start gives a correct full run.
- Simultaneous abort and final DRAIN cycle: abort wins, done stays 0.

Test Plan:
- DIM=8: load A=identity, B[n]=n-32, start -> 64 res_valid pulses, res_data[n]=n-32, done at cycle_count=515, busy low same edge.
- DIM=8, A=B all -128, SAT=0, OUT_W=19 -> every res_data=131072. Same with SAT=1, OUT_W=16 -> every res_data=32767.
- DIM=8, A all 127, B all -128, SAT=1, OUT_W=16 -> -130048 clamped to -32768.
- Abort after 100 cycles of RUN -> busy=0 next edge, no further res_valid, done=0. Restart -> full correct 64-result run.
- reset_n pulled low mid-DRAIN -> all outputs 0 asynchronously. Load writes and start during RUN are ignored: memory unchanged, result pattern matches the original.
- DIM=4, DATA_W=4: A[i][k]=i+k, B[k][j]=k-j, compared against a software model for all 16 elements. Done at cycle_count=67.
